// File: rtl/tdm_demux6.sv
// rtl/tdm_demux6.sv - receive side of a 6:1 TDM link, rebuilds the parallel word
//
// Purpose:
//   Tracks the slot position of a serial bit stream produced by a 6:1 mux.
//   Each strobed bit is steered into its channel position. A complete frame
//   is presented on dout with a one-cycle valid pulse. Framing violations
//   raise a one-cycle frame_err pulse.
//
// Ports:
//   clk        rising-edge system clock
//   rst        synchronous, active-high reset
//   en         bit strobe; din/sync sampled only when high
//   din        serial data bit for the current slot
//   sync       frame marker, high together with the slot-0 bit
//   dout       last complete frame, dout[k] = bit from slot k
//   valid      1-cycle pulse when dout is updated
//   slot       slot index the next strobed bit will fill
//   frame_err  1-cycle pulse on a framing violation
//   locked     high while a frame is being received (RECV state)
module tdm_demux6 #(
  parameter int NCH   = 6,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             sync,
  output logic [NCH-1:0]   dout,
  output logic             valid,
  output logic [SEL_W-1:0] slot,
  output logic             frame_err,
  output logic             locked
);

  typedef enum logic {HUNT, RECV} state_t;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NCH - 1);

  state_t           state, state_nx;
  logic [SEL_W-1:0] slot_nx;
  // Only slots 0..NCH-2 are buffered; the last bit goes straight into dout.
  logic [NCH-2:0]   shift, shift_nx;
  logic [NCH-1:0]   dout_nx;
  logic             valid_nx, ferr_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      slot      <= '0;
      shift     <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      slot      <= slot_nx;
      shift     <= shift_nx;
      dout      <= dout_nx;
      valid     <= valid_nx;
      frame_err <= ferr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    shift_nx = shift;
    dout_nx  = dout;
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;

    if (en) begin
      unique case (state)
        HUNT: begin
          // Bits without sync are discarded silently while hunting.
          if (sync) begin
            shift_nx[0] = din;
            slot_nx     = SEL_W'(1);
            state_nx    = RECV;
          end
        end
        RECV: begin
          if (sync) begin
            // A sync anywhere but slot 0 drops the partial frame; the
            // marked bit always starts a fresh frame.
            ferr_nx     = (slot != '0);
            shift_nx[0] = din;
            slot_nx     = SEL_W'(1);
          end else if (slot == '0) begin
            ferr_nx  = 1'b1;
            state_nx = HUNT;
          end else if (slot == LAST_SLOT) begin
            dout_nx  = {din, shift};
            valid_nx = 1'b1;
            slot_nx  = '0;
          end else begin
            shift_nx[slot] = din;
            slot_nx        = slot + SEL_W'(1);
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  assign locked = (state == RECV);

endmodule
